burst_line_adaptor: RTL and testbench

Converts 256-bit cacheline read/write requests from the last-level cache into the 4×64-bit burst protocol spoken by the testbench `ParamMemory` model. It sits between the cache's memory-side port (`line_*`) and `mem_itf` (`burst_*`), making the cache burst-agnostic. It buffers exactly one outstanding line transaction.

---
 rtl/burst_line_adaptor_pkg.sv | 19 +
 rtl/burst_line_adaptor_if.sv | 38 +++
 rtl/burst_line_adaptor.sv | 126 ++++++++++++
 tb/tb_burst_line_adaptor.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/burst_line_adaptor_pkg.sv
// burst_line_adaptor_pkg: shared types and default widths for the
// cacheline-to-burst adaptor.
package burst_line_adaptor_pkg;

    localparam int LINE_W  = 256;
    localparam int BURST_W = 64;
    localparam int ADDR_W  = 32;
    localparam int BEATS   = LINE_W / BURST_W;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        DONE
    } adaptor_state_t;

    typedef logic [$clog2(BEATS)-1:0] beat_idx_t;

endpackage

// File: rtl/burst_line_adaptor_if.sv
// burst_line_adaptor_if: bundles the cache-side line port and the
// memory-side burst port. The adaptor connects through the slave modport;
// the surrounding cache/memory environment drives the master modport.
interface burst_line_adaptor_if
    import burst_line_adaptor_pkg::*;
#(
    parameter int LINE_WIDTH  = LINE_W,
    parameter int BURST_WIDTH = BURST_W,
    parameter int ADDR_WIDTH  = ADDR_W
);

    // cache side
    logic [LINE_WIDTH-1:0]  line_i;
    logic [LINE_WIDTH-1:0]  line_o;
    logic [ADDR_WIDTH-1:0]  address_i;
    logic                   read_i;
    logic                   write_i;
    logic                   resp_o;

    // memory side
    logic [BURST_WIDTH-1:0] burst_i;
    logic [BURST_WIDTH-1:0] burst_o;
    logic [ADDR_WIDTH-1:0]  address_o;
    logic                   read_o;
    logic                   write_o;
    logic                   resp_i;

    modport master (
        output line_i, address_i, read_i, write_i, burst_i, resp_i,
        input  line_o, resp_o, burst_o, address_o, read_o, write_o
    );

    modport slave (
        input  line_i, address_i, read_i, write_i, burst_i, resp_i,
        output line_o, resp_o, burst_o, address_o, read_o, write_o
    );

endinterface

// File: rtl/burst_line_adaptor.sv
// burst_line_adaptor: turns one cacheline read/write into a 4-beat burst
// and back, holding exactly one line transaction at a time.
// Optional simulation checks: define BURST_LINE_ADAPTOR_ASSERTS_EN.
//
// state | meaning
// IDLE  | waiting for a cache request; read has priority over write
// READ  | read_o high, capturing one burst_i beat per resp_i
// WRITE | write_o high, presenting buffer beat[cnt] on burst_o
// DONE  | one-cycle resp_o pulse, line_o valid; requests ignored
module burst_line_adaptor
    import burst_line_adaptor_pkg::*;
#(
    parameter int LINE_WIDTH  = LINE_W,
    parameter int BURST_WIDTH = BURST_W,
    parameter int ADDR_WIDTH  = ADDR_W
)(
    input  logic clk,
    input  logic rst,
    burst_line_adaptor_if.slave bus
);

    localparam int        NBEATS    = LINE_WIDTH / BURST_WIDTH;
    localparam int        OFF_W     = $clog2(LINE_WIDTH / 8);
    localparam beat_idx_t LAST_BEAT = beat_idx_t'(NBEATS - 1);
    // Clears the byte-within-line bits so memory always sees a line-aligned address.
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK =
        {{(ADDR_WIDTH - OFF_W){1'b1}}, {OFF_W{1'b0}}};

    adaptor_state_t          state;
    beat_idx_t               cnt;
    logic [LINE_WIDTH-1:0]   buffer;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    read_q;
    logic                    write_q;
    logic                    resp_q;

    // Transaction FSM: state, beat counter, line buffer and all strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            buffer  <= '0;
            addr_q  <= '0;
            read_q  <= 1'b0;
            write_q <= 1'b0;
            resp_q  <= 1'b0;
        end else begin
            resp_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.read_i) begin
                        addr_q <= bus.address_i & LINE_MASK;
                        cnt    <= '0;
                        read_q <= 1'b1;
                        state  <= READ;
                    end else if (bus.write_i) begin
                        addr_q  <= bus.address_i & LINE_MASK;
                        buffer  <= bus.line_i;
                        cnt     <= '0;
                        write_q <= 1'b1;
                        state   <= WRITE;
                    end
                end
                READ: begin
                    if (bus.resp_i) begin
                        buffer[int'(cnt) * BURST_WIDTH +: BURST_WIDTH] <= bus.burst_i;
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST_BEAT) begin
                            read_q <= 1'b0;
                            resp_q <= 1'b1;
                            state  <= DONE;
                        end
                    end
                end
                WRITE: begin
                    if (bus.resp_i) begin
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST_BEAT) begin
                            write_q <= 1'b0;
                            resp_q  <= 1'b1;
                            state   <= DONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.address_o = addr_q;
    assign bus.read_o    = read_q;
    assign bus.write_o   = write_q;
    assign bus.resp_o    = resp_q;
    assign bus.line_o    = buffer;
    // Write beat is a pure decode of registered buffer and counter.
    assign bus.burst_o   = buffer[int'(cnt) * BURST_WIDTH +: BURST_WIDTH];

`ifdef BURST_LINE_ADAPTOR_ASSERTS_EN
    a_both_req: assert property (@(posedge clk) disable iff (rst)
        (state == IDLE) |-> !(bus.read_i && bus.write_i))
        else $error("burst_line_adaptor: read_i and write_i both high in IDLE");

    a_resp_idle: assert property (@(posedge clk) disable iff (rst)
        (state == IDLE) |-> !bus.resp_i)
        else $error("burst_line_adaptor: resp_i high in IDLE");

    a_addr_stable: assert property (@(posedge clk) disable iff (rst)
        $changed(addr_q) |-> ($past(rst) || $past(state) == IDLE))
        else $error("burst_line_adaptor: address_o changed outside request accept");

    a_resp_pulse: assert property (@(posedge clk) disable iff (rst)
        resp_q |=> !resp_q)
        else $error("burst_line_adaptor: resp_o high for consecutive cycles");

    a_cnt_ovf: assert property (@(posedge clk) disable iff (rst)
        ((state == READ || state == WRITE) && bus.resp_i && cnt == LAST_BEAT)
        |=> (state == DONE))
        else $error("burst_line_adaptor: beat counter overflow");
`endif

endmodule

// File: tb/tb_burst_line_adaptor.sv
// tb_burst_line_adaptor: directed scenarios with hand-computed expectations.
module tb_burst_line_adaptor;
    import burst_line_adaptor_pkg::*;

    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;

    burst_line_adaptor_if bus ();

    burst_line_adaptor dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // advance one cycle; drive and sample 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.line_i    = '0;
        bus.address_i = '0;
        bus.read_i    = 1'b0;
        bus.write_i   = 1'b0;
        bus.burst_i   = '0;
        bus.resp_i    = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        tests_run++;
        if ({bus.read_o, bus.write_o, bus.resp_o} !== 3'b000) begin
            $display("FAIL reset_strobes: got %b want 000", {bus.read_o, bus.write_o, bus.resp_o});
            tests_failed++;
        end
        tests_run++;
        if (bus.address_o !== 32'h0 || bus.line_o !== '0 || bus.burst_o !== 64'h0) begin
            $display("FAIL reset_data: addr=%h burst=%h line=%h want all 0", bus.address_o, bus.burst_o, bus.line_o);
            tests_failed++;
        end
        rst = 1'b0;
        tick();
        tests_run++;
        if ({bus.read_o, bus.write_o, bus.resp_o} !== 3'b000) begin
            $display("FAIL reset_idle_quiet: got %b want 000", {bus.read_o, bus.write_o, bus.resp_o});
            tests_failed++;
        end
    endtask

    task automatic test_read_b2b();
        logic [63:0] beats [4];
        beats[0] = 64'h1111_1111_1111_1111;
        beats[1] = 64'h2222_2222_2222_2222;
        beats[2] = 64'h3333_3333_3333_3333;
        beats[3] = 64'h4444_4444_4444_4444;
        bus.address_i = 32'h0000_1234;
        bus.read_i    = 1'b1;
        tick();
        tests_run++;
        if (bus.read_o !== 1'b1 || bus.address_o !== 32'h0000_1220) begin
            $display("FAIL read_start: read_o=%b addr=%h want 1 00001220", bus.read_o, bus.address_o);
            tests_failed++;
        end
        for (int i = 0; i < 4; i++) begin
            bus.resp_i  = 1'b1;
            bus.burst_i = beats[i];
            tick();
            if (i < 3) begin
                tests_run++;
                if (bus.resp_o !== 1'b0 || bus.read_o !== 1'b1) begin
                    $display("FAIL read_midburst beat %0d: resp_o=%b read_o=%b want 0 1", i, bus.resp_o, bus.read_o);
                    tests_failed++;
                end
            end
        end
        bus.resp_i = 1'b0;
        tests_run++;
        if (bus.resp_o !== 1'b1 || bus.read_o !== 1'b0) begin
            $display("FAIL read_done: resp_o=%b read_o=%b want 1 0", bus.resp_o, bus.read_o);
            tests_failed++;
        end
        tests_run++;
        if (bus.line_o !== {beats[3], beats[2], beats[1], beats[0]}) begin
            $display("FAIL read_line: got %h want %h", bus.line_o, {beats[3], beats[2], beats[1], beats[0]});
            tests_failed++;
        end
        bus.read_i = 1'b0;
        tick();
        tests_run++;
        if (bus.resp_o !== 1'b0 || bus.address_o !== 32'h0000_1220) begin
            $display("FAIL read_resp_single: resp_o=%b addr=%h want 0 00001220", bus.resp_o, bus.address_o);
            tests_failed++;
        end
        tick();
    endtask

    task automatic test_write();
        logic [63:0] d [4];
        d[0] = 64'hD000_0000_0000_00A0;
        d[1] = 64'hD111_1111_1111_11A1;
        d[2] = 64'hD222_2222_2222_22A2;
        d[3] = 64'hD333_3333_3333_33A3;
        bus.line_i    = {d[3], d[2], d[1], d[0]};
        bus.address_i = 32'h0000_2008;
        bus.write_i   = 1'b1;
        tick();
        tests_run++;
        if (bus.write_o !== 1'b1 || bus.read_o !== 1'b0 || bus.address_o !== 32'h0000_2000) begin
            $display("FAIL write_start: write_o=%b read_o=%b addr=%h want 1 0 00002000", bus.write_o, bus.read_o, bus.address_o);
            tests_failed++;
        end
        bus.line_i = '1;
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (bus.burst_o !== d[i]) begin
                $display("FAIL write_beat %0d: got %h want %h", i, bus.burst_o, d[i]);
                tests_failed++;
            end
            bus.resp_i = 1'b1;
            tick();
        end
        bus.resp_i = 1'b0;
        tests_run++;
        if (bus.write_o !== 1'b0 || bus.resp_o !== 1'b1) begin
            $display("FAIL write_done: write_o=%b resp_o=%b want 0 1", bus.write_o, bus.resp_o);
            tests_failed++;
        end
        bus.write_i = 1'b0;
        tick();
        tests_run++;
        if (bus.resp_o !== 1'b0 || bus.write_o !== 1'b0) begin
            $display("FAIL write_resp_single: resp_o=%b write_o=%b want 0 0", bus.resp_o, bus.write_o);
            tests_failed++;
        end
        bus.line_i = '0;
        tick();
    endtask

    task automatic test_gapped_read();
        logic        pat [7];
        logic [63:0] val [7];
        logic [255:0] exp_line;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 7; i++) val[i] = 64'hA0A0_0000_0000_0000 | 64'(i);
        exp_line = {val[6], val[4], val[3], val[0]};
        bus.address_i = 32'h0000_0300;
        bus.read_i    = 1'b1;
        tick();
        for (int i = 0; i < 7; i++) begin
            bus.resp_i  = pat[i];
            bus.burst_i = val[i];
            tick();
            if (i < 6) begin
                tests_run++;
                if (bus.resp_o !== 1'b0) begin
                    $display("FAIL gap_early_resp cycle %0d: resp_o=%b want 0", i, bus.resp_o);
                    tests_failed++;
                end
            end
        end
        bus.resp_i = 1'b0;
        tests_run++;
        if (bus.resp_o !== 1'b1 || bus.line_o !== exp_line) begin
            $display("FAIL gap_line: resp_o=%b line=%h want 1 %h", bus.resp_o, bus.line_o, exp_line);
            tests_failed++;
        end
        bus.read_i = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_simultaneous();
        logic saw_write;
        saw_write = 1'b0;
        bus.address_i = 32'h0000_0480;
        bus.line_i    = {4{64'hBAD0_BAD0_BAD0_BAD0}};
        bus.read_i    = 1'b1;
        bus.write_i   = 1'b1;
        tick();
        tests_run++;
        if (bus.read_o !== 1'b1) begin
            $display("FAIL simul_read_wins: read_o=%b want 1", bus.read_o);
            tests_failed++;
        end
        for (int i = 0; i < 4; i++) begin
            if (bus.write_o !== 1'b0) saw_write = 1'b1;
            bus.resp_i  = 1'b1;
            bus.burst_i = 64'hC000_0000_0000_0000 | 64'(i);
            tick();
        end
        bus.resp_i = 1'b0;
        if (bus.write_o !== 1'b0) saw_write = 1'b1;
        tests_run++;
        if (bus.resp_o !== 1'b1 || bus.line_o[63:0] !== 64'hC000_0000_0000_0000) begin
            $display("FAIL simul_done: resp_o=%b beat0=%h want 1 c000000000000000", bus.resp_o, bus.line_o[63:0]);
            tests_failed++;
        end
        bus.read_i  = 1'b0;
        bus.write_i = 1'b0;
        tick();
        if (bus.write_o !== 1'b0) saw_write = 1'b1;
        tests_run++;
        if (saw_write !== 1'b0) begin
            $display("FAIL simul_no_write: write_o seen=%b want 0", saw_write);
            tests_failed++;
        end
        tick();
    endtask

    task automatic test_reset_mid_write();
        logic [63:0] rb [4];
        bus.line_i    = {64'hE3E3_E3E3_E3E3_E3E3, 64'hE2E2_E2E2_E2E2_E2E2,
                         64'hE1E1_E1E1_E1E1_E1E1, 64'hE0E0_E0E0_E0E0_E0E0};
        bus.address_i = 32'h0000_5500;
        bus.write_i   = 1'b1;
        tick();
        bus.resp_i = 1'b1;
        tick();
        tick();
        tests_run++;
        if (bus.burst_o !== 64'hE2E2_E2E2_E2E2_E2E2) begin
            $display("FAIL rst_pre_beat2: got %h want e2e2e2e2e2e2e2e2", bus.burst_o);
            tests_failed++;
        end
        bus.resp_i  = 1'b0;
        bus.write_i = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests_run++;
        if ({bus.read_o, bus.write_o, bus.resp_o} !== 3'b000 || bus.address_o !== 32'h0
            || bus.burst_o !== 64'h0 || bus.line_o !== '0) begin
            $display("FAIL rst_mid_outputs: rd=%b wr=%b resp=%b addr=%h burst=%h want all 0",
                     bus.read_o, bus.write_o, bus.resp_o, bus.address_o, bus.burst_o);
            tests_failed++;
        end
        rb[0] = 64'h0F0F_0000_0000_0000;
        rb[1] = 64'h0F0F_0000_0000_0001;
        rb[2] = 64'h0F0F_0000_0000_0002;
        rb[3] = 64'h0F0F_0000_0000_0003;
        bus.address_i = 32'h0000_0040;
        bus.read_i    = 1'b1;
        tick();
        tests_run++;
        if (bus.read_o !== 1'b1 || bus.address_o !== 32'h0000_0040) begin
            $display("FAIL rst_then_read_start: read_o=%b addr=%h want 1 00000040", bus.read_o, bus.address_o);
            tests_failed++;
        end
        for (int i = 0; i < 4; i++) begin
            bus.resp_i  = 1'b1;
            bus.burst_i = rb[i];
            tick();
        end
        bus.resp_i = 1'b0;
        tests_run++;
        if (bus.resp_o !== 1'b1 || bus.line_o !== {rb[3], rb[2], rb[1], rb[0]}) begin
            $display("FAIL rst_then_read_line: resp_o=%b line=%h want 1 %h", bus.resp_o, bus.line_o, {rb[3], rb[2], rb[1], rb[0]});
            tests_failed++;
        end
        bus.read_i = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_back_to_back();
        logic [63:0] w [4];
        w[0] = 64'h5A5A_0000_0000_0000;
        w[1] = 64'h5A5A_0000_0000_1111;
        w[2] = 64'h5A5A_0000_0000_2222;
        w[3] = 64'h5A5A_0000_0000_3333;
        bus.address_i = 32'h0000_0100;
        bus.read_i    = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            bus.resp_i  = 1'b1;
            bus.burst_i = 64'h7700_0000_0000_0000 | 64'(i);
            tick();
        end
        bus.resp_i = 1'b0;
        tests_run++;
        if (bus.resp_o !== 1'b1) begin
            $display("FAIL b2b_read_done: resp_o=%b want 1", bus.resp_o);
            tests_failed++;
        end
        // request still held through DONE must not be re-accepted
        tick();
        tests_run++;
        if (bus.read_o !== 1'b0 || bus.resp_o !== 1'b0) begin
            $display("FAIL b2b_no_reaccept: read_o=%b resp_o=%b want 0 0", bus.read_o, bus.resp_o);
            tests_failed++;
        end
        bus.read_i    = 1'b0;
        bus.write_i   = 1'b1;
        bus.address_i = 32'h0000_0A3F;
        bus.line_i    = {w[3], w[2], w[1], w[0]};
        tick();
        tests_run++;
        if (bus.write_o !== 1'b1 || bus.read_o !== 1'b0 || bus.address_o !== 32'h0000_0A20) begin
            $display("FAIL b2b_write_start: write_o=%b read_o=%b addr=%h want 1 0 00000a20", bus.write_o, bus.read_o, bus.address_o);
            tests_failed++;
        end
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (bus.burst_o !== w[i]) begin
                $display("FAIL b2b_write_beat %0d: got %h want %h", i, bus.burst_o, w[i]);
                tests_failed++;
            end
            bus.resp_i = 1'b1;
            tick();
        end
        bus.resp_i = 1'b0;
        tests_run++;
        if (bus.resp_o !== 1'b1 || bus.write_o !== 1'b0) begin
            $display("FAIL b2b_write_done: resp_o=%b write_o=%b want 1 0", bus.resp_o, bus.write_o);
            tests_failed++;
        end
        bus.write_i = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;
        idle_inputs();
        test_reset();
        test_read_b2b();
        test_write();
        test_gapped_read();
        test_simultaneous();
        test_reset_mid_write();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
